// File: rtl/tensor_core_pkg.sv
// Shared types, widths and saturation helpers for the tensor core matmul block.
package tensor_core_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned MATRIX_DIM = 3;
   localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 2;
   localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
   localparam int unsigned IDX_WIDTH  = $clog2(MATRIX_DIM);

   typedef logic signed [DATA_WIDTH-1:0] tensor_element_t;
   typedef logic signed [PROD_WIDTH-1:0] tensor_prod_t;
   typedef logic signed [ACC_WIDTH-1:0]  tensor_acc_t;
   typedef logic        [IDX_WIDTH-1:0]  tensor_idx_t;

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      STORE,
      WRITEBACK,
      DONE
   } seq_state_t;

   localparam tensor_acc_t ELEM_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam tensor_acc_t ELEM_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

   // True when the accumulator value does not fit in one element.
   function automatic logic is_saturated(input tensor_acc_t value);
      return (value > ELEM_MAX) || (value < ELEM_MIN);
   endfunction

   // Clamp an accumulator value to the signed element range.
   function automatic tensor_element_t saturate(input tensor_acc_t value);
      if (value > ELEM_MAX) begin
         return DATA_WIDTH'(ELEM_MAX);
      end else if (value < ELEM_MIN) begin
         return DATA_WIDTH'(ELEM_MIN);
      end else begin
         return DATA_WIDTH'(value);
      end
   endfunction

endpackage

// File: rtl/tensor_core_mac_unit.sv
// Shared signed multiply-accumulate with clear and a saturating narrow output.
module tensor_core_mac_unit
   import tensor_core_pkg::*;
(
   input  logic            clock_in,
   input  logic            reset_in,
   input  logic            enable_in,
   input  logic            clear_in,
   input  tensor_element_t a_in,
   input  tensor_element_t b_in,
   output tensor_element_t sat_c,
   output logic            ovf_c
);

   tensor_acc_t  acc;
   tensor_prod_t prod_c;
   tensor_acc_t  base_c;

   // Full-precision signed product and accumulate base (cleared on the first term).
   assign prod_c = tensor_prod_t'(a_in) * tensor_prod_t'(b_in);
   assign base_c = clear_in ? '0 : acc;

   // Accumulator register; 18 bits cannot wrap for a 3-term dot product.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         acc <= '0;
      end else if (enable_in) begin
         acc <= base_c + ACC_WIDTH'(prod_c);
      end
   end

   // Narrowed result and clamp indication for the completed dot product.
   assign sat_c = saturate(acc);
   assign ovf_c = is_saturated(acc);

endmodule

// File: rtl/tensor_core_matmul_sequencer.sv
// Sequences a 3x3 signed matmul C = M0 x M1 through one MAC and writes C back into M0.
module tensor_core_matmul_sequencer
   import tensor_core_pkg::*;
(
   input  logic            clock_in,
   input  logic            reset_in,
   input  logic            start_in,
   output logic            busy_out,
   output logic            done_out,
   output logic            overflow_out,
   output tensor_idx_t     a_row_out,
   output tensor_idx_t     a_col_out,
   input  tensor_element_t a_data_in,
   output tensor_idx_t     b_row_out,
   output tensor_idx_t     b_col_out,
   input  tensor_element_t b_data_in,
   output logic            write_enable_out,
   output tensor_idx_t     write_row_out,
   output tensor_idx_t     write_col_out,
   output tensor_element_t write_data_out
);

   localparam tensor_idx_t LAST_IDX = IDX_WIDTH'(MATRIX_DIM - 1);

   seq_state_t      state;
   tensor_idx_t     i_idx;
   tensor_idx_t     j_idx;
   tensor_idx_t     k_idx;
   tensor_element_t result_buf [MATRIX_DIM][MATRIX_DIM];

   tensor_element_t mac_sat_c;
   logic            mac_ovf_c;
   tensor_idx_t     next_i_c;
   tensor_idx_t     next_j_c;
   tensor_idx_t     wb_next_row_c;
   tensor_idx_t     wb_next_col_c;

   // Single shared MAC; the first term of every dot product clears the accumulator.
   tensor_core_mac_unit u_mac (
      .clock_in  (clock_in),
      .reset_in  (reset_in),
      .enable_in (state == MAC),
      .clear_in  (k_idx == '0),
      .a_in      (a_data_in),
      .b_in      (b_data_in),
      .sat_c     (mac_sat_c),
      .ovf_c     (mac_ovf_c)
   );

   // Row-major successors for the result position and the writeback position.
   assign next_j_c      = (j_idx == LAST_IDX) ? '0 : IDX_WIDTH'(j_idx + 1'b1);
   assign next_i_c      = (j_idx == LAST_IDX) ? IDX_WIDTH'(i_idx + 1'b1) : i_idx;
   assign wb_next_col_c = (write_col_out == LAST_IDX) ? '0 : IDX_WIDTH'(write_col_out + 1'b1);
   assign wb_next_row_c = (write_col_out == LAST_IDX) ? IDX_WIDTH'(write_row_out + 1'b1)
                                                      : write_row_out;

   // Sequencer FSM; outputs are loaded on the edge entering the state they belong to.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state            <= IDLE;
         i_idx            <= '0;
         j_idx            <= '0;
         k_idx            <= '0;
         busy_out         <= 1'b0;
         done_out         <= 1'b0;
         overflow_out     <= 1'b0;
         a_row_out        <= '0;
         a_col_out        <= '0;
         b_row_out        <= '0;
         b_col_out        <= '0;
         write_enable_out <= 1'b0;
         write_row_out    <= '0;
         write_col_out    <= '0;
         write_data_out   <= '0;
         for (int unsigned r = 0; r < MATRIX_DIM; r++) begin
            for (int unsigned c = 0; c < MATRIX_DIM; c++) begin
               result_buf[r][c] <= '0;
            end
         end
      end else begin
         done_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  state        <= MAC;
                  i_idx        <= '0;
                  j_idx        <= '0;
                  k_idx        <= '0;
                  busy_out     <= 1'b1;
                  overflow_out <= 1'b0;
                  a_row_out    <= '0;
                  a_col_out    <= '0;
                  b_row_out    <= '0;
                  b_col_out    <= '0;
               end
            end
            MAC: begin
               if (k_idx == LAST_IDX) begin
                  state     <= STORE;
                  k_idx     <= '0;
                  a_row_out <= '0;
                  a_col_out <= '0;
                  b_row_out <= '0;
                  b_col_out <= '0;
               end else begin
                  k_idx     <= IDX_WIDTH'(k_idx + 1'b1);
                  a_col_out <= IDX_WIDTH'(k_idx + 1'b1);
                  b_row_out <= IDX_WIDTH'(k_idx + 1'b1);
               end
            end
            STORE: begin
               result_buf[i_idx][j_idx] <= mac_sat_c;
               if (mac_ovf_c) begin
                  overflow_out <= 1'b1;
               end
               if ((i_idx == LAST_IDX) && (j_idx == LAST_IDX)) begin
                  state            <= WRITEBACK;
                  i_idx            <= '0;
                  j_idx            <= '0;
                  write_enable_out <= 1'b1;
                  write_row_out    <= '0;
                  write_col_out    <= '0;
                  write_data_out   <= result_buf[0][0];
               end else begin
                  state     <= MAC;
                  i_idx     <= next_i_c;
                  j_idx     <= next_j_c;
                  a_row_out <= next_i_c;
                  b_col_out <= next_j_c;
               end
            end
            WRITEBACK: begin
               if ((write_row_out == LAST_IDX) && (write_col_out == LAST_IDX)) begin
                  state            <= DONE;
                  busy_out         <= 1'b0;
                  done_out         <= 1'b1;
                  write_enable_out <= 1'b0;
                  write_row_out    <= '0;
                  write_col_out    <= '0;
                  write_data_out   <= '0;
               end else begin
                  write_row_out  <= wb_next_row_c;
                  write_col_out  <= wb_next_col_c;
                  write_data_out <= result_buf[wb_next_row_c][wb_next_col_c];
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
